// File: rtl/sprite_pkg.sv
// Shared types, widths and reset-placement constants for the sprite motion controller.
package sprite_pkg;

    localparam int ID_W       = 2;
    localparam int POS_W      = 12;
    localparam int RST_STEP_X = 40;
    localparam int RST_STEP_Y = 24;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
        logic             dir_x;
        logic             dir_y;
    } box_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        COMMIT = 2'd2
    } fsm_state_t;

    // Boxes start on a diagonal staircase; odd boxes head left so they cross early.
    function automatic box_state_t reset_box(input int unsigned idx,
                                             input int unsigned min_x,
                                             input int unsigned min_y);
        box_state_t b;
        b.x     = POS_W'(min_x + RST_STEP_X * idx);
        b.y     = POS_W'(min_y + RST_STEP_Y * idx);
        b.dir_x = ((idx % 2) == 0) ? DIR_POS : DIR_NEG;
        b.dir_y = DIR_POS;
        return b;
    endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// Combinational single-axis step: moves a position by STEP and bounces it
// off [MIN, MAX-SIZE], reversing direction at the wall.
module sprite_axis_step
    import sprite_pkg::*;
#(
    parameter int MIN  = 10,
    parameter int MAX  = 640,
    parameter int SIZE = 32,
    parameter int STEP = 1
) (
    input  logic [POS_W-1:0] i_pos,
    input  logic             i_dir,
    output logic [POS_W-1:0] o_pos,
    output logic             o_dir
);

    localparam logic [POS_W:0] HI    = (POS_W+1)'(MAX - SIZE);
    localparam logic [POS_W:0] LO    = (POS_W+1)'(MIN);
    localparam logic [POS_W:0] LO_TH = (POS_W+1)'(MIN + STEP);

    logic [POS_W:0] w_pos;
    logic [POS_W:0] w_inc;
    logic [POS_W:0] w_dec;

    assign w_pos = {1'b0, i_pos};
    assign w_inc = w_pos + (POS_W+1)'(STEP);
    assign w_dec = w_pos - (POS_W+1)'(STEP);

    always_comb begin
        o_pos = i_pos;
        o_dir = i_dir;
        if (i_dir == DIR_POS) begin
            if (w_inc > HI) begin
                o_pos = HI[POS_W-1:0];
                o_dir = DIR_NEG;
            end else begin
                o_pos = w_inc[POS_W-1:0];
            end
        end else begin
            if (w_pos < LO_TH) begin
                o_pos = LO[POS_W-1:0];
                o_dir = DIR_POS;
            end else begin
                o_pos = w_dec[POS_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Bouncing overlay-box controller: vblank update engine plus registered pixel hit test.
// Optional SPRITE_COLLISION_EN adds collide / collide_sticky outputs.
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int N_BOXES   = 4,
    parameter int BOX_SIZE  = 32,
    parameter int MIN_X     = 10,
    parameter int MIN_Y     = 10,
    parameter int MAX_X     = 640,
    parameter int MAX_Y     = 480,
    parameter int STEP      = 1,
    parameter int FRAME_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             enable,
    input  logic [POS_W-1:0] x,
    input  logic [POS_W-1:0] y,
    input  logic             pix_valid,
    output logic             hit,
    output logic [ID_W-1:0]  hit_id,
    output logic             busy
`ifdef SPRITE_COLLISION_EN
    ,
    output logic             collide,
    output logic             collide_sticky
`endif
);

    box_state_t  r_work [N_BOXES];
    box_state_t  r_disp [N_BOXES];
    fsm_state_t  r_state;
    logic [ID_W-1:0] r_idx;
    logic [7:0]  r_div_cnt;
    logic        r_hit;
    logic [ID_W-1:0] r_hit_id;

    box_state_t  w_cur;
    logic [POS_W-1:0] w_x_next;
    logic [POS_W-1:0] w_y_next;
    logic        w_dx_next;
    logic        w_dy_next;
    logic [N_BOXES-1:0] w_match;
    logic [ID_W-1:0] w_hit_id;
    logic        w_found;

    // One step unit per axis, time-shared across boxes by r_idx.
    assign w_cur = r_work[r_idx];

    sprite_axis_step #(.MIN(MIN_X), .MAX(MAX_X), .SIZE(BOX_SIZE), .STEP(STEP)) u_step_x (
        .i_pos (w_cur.x),
        .i_dir (w_cur.dir_x),
        .o_pos (w_x_next),
        .o_dir (w_dx_next)
    );

    sprite_axis_step #(.MIN(MIN_Y), .MAX(MAX_Y), .SIZE(BOX_SIZE), .STEP(STEP)) u_step_y (
        .i_pos (w_cur.y),
        .i_dir (w_cur.dir_y),
        .o_pos (w_y_next),
        .o_dir (w_dy_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_div_cnt <= '0;
            for (int unsigned i = 0; i < N_BOXES; i++) begin
                r_work[i] <= reset_box(i, MIN_X, MIN_Y);
                r_disp[i] <= reset_box(i, MIN_X, MIN_Y);
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame_start && enable) begin
                        if (r_div_cnt == 8'(FRAME_DIV - 1)) begin
                            r_div_cnt <= '0;
                            r_idx     <= '0;
                            r_state   <= UPDATE;
                        end else begin
                            r_div_cnt <= r_div_cnt + 8'd1;
                        end
                    end
                end
                UPDATE: begin
                    r_work[r_idx] <= '{x: w_x_next, y: w_y_next, dir_x: w_dx_next, dir_y: w_dy_next};
                    if (r_idx == ID_W'(N_BOXES - 1)) begin
                        r_state <= COMMIT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                COMMIT: begin
                    for (int unsigned i = 0; i < N_BOXES; i++) begin
                        r_disp[i] <= r_work[i];
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_match = '0;
        for (int unsigned i = 0; i < N_BOXES; i++) begin
            w_match[i] = pix_valid
                && ({1'b0, x} >= {1'b0, r_disp[i].x})
                && ({1'b0, x} <  ({1'b0, r_disp[i].x} + (POS_W+1)'(BOX_SIZE)))
                && ({1'b0, y} >= {1'b0, r_disp[i].y})
                && ({1'b0, y} <  ({1'b0, r_disp[i].y} + (POS_W+1)'(BOX_SIZE)));
        end
    end

    always_comb begin
        w_hit_id = '0;
        w_found  = 1'b0;
        for (int unsigned i = 0; i < N_BOXES; i++) begin
            if (w_match[i] && !w_found) begin
                w_hit_id = ID_W'(i);
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit    <= 1'b0;
            r_hit_id <= '0;
        end else begin
            r_hit    <= |w_match;
            r_hit_id <= w_hit_id;
        end
    end

    assign hit    = r_hit;
    assign hit_id = r_hit_id;
    assign busy   = (r_state != IDLE);

`ifdef SPRITE_COLLISION_EN
    logic r_collide;
    logic r_collide_sticky;
    logic w_multi;

    // Clearing the lowest set bit leaves something only when two or more boxes match.
    assign w_multi = |(w_match & (w_match - N_BOXES'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_collide        <= 1'b0;
            r_collide_sticky <= 1'b0;
        end else begin
            r_collide        <= w_multi;
            r_collide_sticky <= w_multi | (r_collide_sticky & ~frame_start);
        end
    end

    assign collide        = r_collide;
    assign collide_sticky = r_collide_sticky;
`endif

endmodule
